// File: rtl/hci_core_load_store_arbiter_if.sv
// Shared HCI core parameter defaults and the hci_core_intf bundle.
// Master drives request payload and lrdy; slave drives grant and response.
package hci_package;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_BW = 8;
  localparam int unsigned DEFAULT_WW = 32;
  localparam int unsigned DEFAULT_UW = 1;
endpackage

interface hci_core_intf #(
  parameter int unsigned DW = hci_package::DEFAULT_DW,
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned BW = hci_package::DEFAULT_BW,
  parameter int unsigned OW = 1,
  parameter int unsigned UW = hci_package::DEFAULT_UW
) ();
  logic           req;
  logic           gnt;
  logic [AW-1:0]  add;
  logic           wen;
  logic [DW-1:0]  data;
  logic [DW/BW-1:0] be;
  logic [OW-1:0]  boffs;
  logic [UW-1:0]  user;
  logic           lrdy;
  logic [DW-1:0]  r_data;
  logic           r_valid;
  logic           r_opc;
  logic [UW-1:0]  r_user;

  modport master (
    output req, add, wen, data, be, boffs, user, lrdy,
    input  gnt, r_data, r_valid, r_opc, r_user
  );

  modport slave (
    input  req, add, wen, data, be, boffs, user, lrdy,
    output gnt, r_data, r_valid, r_opc, r_user
  );
endinterface

// File: rtl/hci_core_load_store_arbiter.sv
// LOAD/STORE weighted round-robin arbiter with in-order tag FIFO.
// Starvation guard enabled by HCI_LS_ARBITER_STARVATION_EN.
module hci_core_load_store_arbiter
  import hci_package::*;
#(
  parameter int unsigned DW              = DEFAULT_DW,
  parameter int unsigned AW              = DEFAULT_AW,
  parameter int unsigned BW              = DEFAULT_BW,
  parameter int unsigned WW              = DEFAULT_WW,
  parameter int unsigned OW              = 1,
  parameter int unsigned UW              = DEFAULT_UW,
  parameter int unsigned LOAD_WEIGHT     = 2,
  parameter int unsigned STORE_WEIGHT    = 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned MAX_STALL       = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  hci_core_intf.slave  in_load,
  hci_core_intf.slave  in_store,
  hci_core_intf.master out,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic starve_o,
  output logic err_o
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned WMAX =
    (LOAD_WEIGHT > STORE_WEIGHT) ? LOAD_WEIGHT : STORE_WEIGHT;
  localparam int unsigned KW = $clog2(WMAX + 1);

  typedef enum logic {
    TURN_LOAD,
    TURN_STORE
  } turn_e;

  turn_e  turn_q, turn_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic err_q, err_d;

  logic full, empty, both;
  logic sel_store, force_sel;
  logic beat, push, pop, head;
  logic l_sat, s_sat;
  logic [KW-1:0] wlast;

  logic unused_cfg;
  assign unused_cfg =
    (DW + AW + BW + WW + OW + UW + MAX_STALL) == 0;

  assign full  = occ_q == (PW+1)'(MAX_OUTSTANDING);
  assign empty = occ_q == '0;
  assign both  = in_load.req & in_store.req;

`ifdef HCI_LS_ARBITER_STARVATION_EN
  localparam int unsigned SW = $clog2(MAX_STALL + 1);

  logic [SW-1:0] lw_q, lw_d;
  logic [SW-1:0] sw_q, sw_d;

  assign l_sat = lw_q == SW'(MAX_STALL);
  assign s_sat = sw_q == SW'(MAX_STALL);

  always_comb begin
    lw_d = lw_q;
    sw_d = sw_q;
    if (!in_load.req || in_load.gnt) begin
      lw_d = '0;
    end else if (!l_sat) begin
      lw_d = lw_q + 1'b1;
    end
    if (!in_store.req || in_store.gnt) begin
      sw_d = '0;
    end else if (!s_sat) begin
      sw_d = sw_q + 1'b1;
    end
    if (clear_i) begin
      lw_d = '0;
      sw_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lw_q <= '0;
      sw_q <= '0;
    end else begin
      lw_q <= lw_d;
      sw_q <= sw_d;
    end
  end
`else
  assign l_sat = 1'b0;
  assign s_sat = 1'b0;
`endif

  // Forced grants only arise when both channels contend.
  always_comb begin
    sel_store = 1'b0;
    force_sel = 1'b0;
    unique case (1'b1)
      in_load.req & ~in_store.req: sel_store = 1'b0;
      ~in_load.req & in_store.req: sel_store = 1'b1;
      both & s_sat: begin
        sel_store = 1'b1;
        force_sel = 1'b1;
      end
      both & ~s_sat & l_sat: begin
        sel_store = 1'b0;
        force_sel = 1'b1;
      end
      both & ~s_sat & ~l_sat:
        sel_store = turn_q == TURN_STORE;
      default: sel_store = 1'b0;
    endcase
  end

  assign out.req   = (in_load.req | in_store.req) & ~full;
  assign out.add   = sel_store ? in_store.add   : in_load.add;
  assign out.wen   = sel_store ? in_store.wen   : in_load.wen;
  assign out.data  = sel_store ? in_store.data  : in_load.data;
  assign out.be    = sel_store ? in_store.be    : in_load.be;
  assign out.boffs = sel_store ? in_store.boffs : in_load.boffs;
  assign out.user  = sel_store ? in_store.user  : in_load.user;

  assign beat         = out.req & out.gnt;
  assign in_load.gnt  = beat & ~sel_store;
  assign in_store.gnt = beat & sel_store;
  assign starve_o     = beat & force_sel;

  assign push = beat;
  assign pop  = out.r_valid & ~empty;
  assign head = tag_q[rptr_q];

  assign in_load.r_valid  = pop & ~head;
  assign in_store.r_valid = pop & head;
  assign in_load.r_data   = out.r_data;
  assign in_store.r_data  = out.r_data;
  assign in_load.r_opc    = out.r_opc;
  assign in_store.r_opc   = out.r_opc;
  assign in_load.r_user   = out.r_user;
  assign in_store.r_user  = out.r_user;

  assign out.lrdy = empty ? 1'b1 :
                    head  ? in_store.lrdy : in_load.lrdy;

  assign wlast = (turn_q == TURN_LOAD) ?
                 KW'(LOAD_WEIGHT - 1) : KW'(STORE_WEIGHT - 1);

  always_comb begin
    turn_d = turn_q;
    cnt_d  = cnt_q;
    tag_d  = tag_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    occ_d  = occ_q;
    err_d  = err_q | (out.r_valid & empty);
    if (beat && (sel_store == (turn_q == TURN_STORE))) begin
      if (cnt_q == wlast) begin
        turn_d = (turn_q == TURN_LOAD) ? TURN_STORE : TURN_LOAD;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (push) begin
      tag_d[wptr_q] = sel_store;
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (clear_i) begin
      turn_d = TURN_LOAD;
      cnt_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
      occ_d  = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      turn_q <= TURN_LOAD;
      cnt_q  <= '0;
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      turn_q <= turn_d;
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  assign outstanding_o = occ_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_hci_core_load_store_arbiter.sv
// Directed bench for hci_core_load_store_arbiter.
// Second instance uses LOAD_WEIGHT=16 for the starvation scenario.
module tb_hci_core_load_store_arbiter;

`ifdef HCI_LS_ARBITER_STARVATION_EN
  localparam bit STV = 1'b1;
`else
  localparam bit STV = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_i;
  always #5 clk_i = ~clk_i;

  hci_core_intf ld ();
  hci_core_intf st ();
  hci_core_intf o ();
  hci_core_intf ld2 ();
  hci_core_intf st2 ();
  hci_core_intf o2 ();

  logic [2:0] occ, occ2;
  logic starve, starve2, err, err2;

  hci_core_load_store_arbiter u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .in_load       (ld),
    .in_store      (st),
    .out           (o),
    .outstanding_o (occ),
    .starve_o      (starve),
    .err_o         (err)
  );

  hci_core_load_store_arbiter #(
    .LOAD_WEIGHT (16)
  ) u_stv (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .in_load       (ld2),
    .in_store      (st2),
    .out           (o2),
    .outstanding_o (occ2),
    .starve_o      (starve2),
    .err_o         (err2)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic mid;
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit exp_s, prev_s;
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    ld.req = 0; ld.add = 32'h100; ld.wen = 1; ld.data = 0;
    ld.be = '1; ld.boffs = 0; ld.user = 0; ld.lrdy = 1;
    st.req = 0; st.add = 32'h200; st.wen = 0; st.data = 32'h55;
    st.be = '1; st.boffs = 0; st.user = 1; st.lrdy = 0;
    o.gnt = 0; o.r_data = 0; o.r_valid = 0; o.r_opc = 0; o.r_user = 0;
    ld2.req = 0; ld2.add = 32'h100; ld2.wen = 1; ld2.data = 0;
    ld2.be = '1; ld2.boffs = 0; ld2.user = 0; ld2.lrdy = 1;
    st2.req = 0; st2.add = 32'h200; st2.wen = 0; st2.data = 0;
    st2.be = '1; st2.boffs = 0; st2.user = 0; st2.lrdy = 1;
    o2.gnt = 0; o2.r_data = 0; o2.r_valid = 0; o2.r_opc = 0;
    o2.r_user = 0;

    // reset state
    tick;
    tick;
    mid;
    chk("rst_occ", occ, 0);
    chk("rst_err", err, 0);
    chk("rst_starve", starve, 0);
    chk("rst_req", o.req, 0);
    chk("rst_ld_gnt", ld.gnt, 0);
    rst_ni = 1'b1;
    tick;

    // weighted sharing L,L,S,L,L,S with a response every cycle
    o.gnt = 1; ld.req = 1; st.req = 1;
    prev_s = 0;
    for (int k = 0; k < 6; k++) begin
      o.r_valid = (k > 0);
      mid;
      exp_s = (k % 3 == 2);
      chk("wrr_ld_gnt", ld.gnt, !exp_s);
      chk("wrr_st_gnt", st.gnt, exp_s);
      chk("wrr_add", o.add, exp_s ? 32'h200 : 32'h100);
      if (k > 0) begin
        chk("wrr_ld_rv", ld.r_valid, !prev_s);
        chk("wrr_st_rv", st.r_valid, prev_s);
      end
      prev_s = exp_s;
      tick;
    end
    ld.req = 0; st.req = 0; o.r_valid = 1;
    mid;
    chk("wrr_last_rv", st.r_valid, 1);
    tick;
    o.r_valid = 0;
    mid;
    chk("wrr_occ", occ, 0);
    tick;

    // response routing: grant L, S, L
    ld.req = 1;
    mid;
    chk("rt_a_ld_gnt", ld.gnt, 1);
    tick;
    ld.req = 0; st.req = 1;
    o.r_valid = 1; o.r_data = 32'hCAFE0001;
    mid;
    chk("rt_b_st_gnt", st.gnt, 1);
    chk("rt_b_ld_rv", ld.r_valid, 1);
    chk("rt_b_st_rv", st.r_valid, 0);
    chk("rt_b_ld_rd", ld.r_data, 32'hCAFE0001);
    chk("rt_b_st_rd", st.r_data, 32'hCAFE0001);
    tick;
    st.req = 0; ld.req = 1;
    mid;
    chk("rt_c_ld_gnt", ld.gnt, 1);
    chk("rt_c_st_rv", st.r_valid, 1);
    chk("rt_c_ld_rv", ld.r_valid, 0);
    chk("rt_c_lrdy", o.lrdy, 0);
    tick;
    ld.req = 0;
    mid;
    chk("rt_d_ld_rv", ld.r_valid, 1);
    tick;
    o.r_valid = 0;
    mid;
    chk("rt_occ", occ, 0);
    tick;

    // FIFO full after four grants without responses
    ld.req = 1;
    for (int k = 0; k < 4; k++) begin
      mid;
      chk("full_fill_gnt", ld.gnt, 1);
      tick;
    end
    mid;
    chk("full_occ", occ, 4);
    chk("full_req", o.req, 0);
    chk("full_ld_gnt", ld.gnt, 0);
    chk("full_st_gnt", st.gnt, 0);
    o.r_valid = 1;
    #1;
    chk("full_pop_gnt", ld.gnt, 0);
    chk("full_pop_rv", ld.r_valid, 1);
    tick;
    o.r_valid = 0;
    mid;
    chk("full_occ3", occ, 3);
    chk("full_regnt", ld.gnt, 1);
    tick;
    ld.req = 0; o.r_valid = 1;
    for (int k = 0; k < 4; k++) tick;
    o.r_valid = 0;
    mid;
    chk("full_drain", occ, 0);
    tick;

    // response with empty FIFO
    o.r_valid = 1;
    mid;
    chk("err_ld_rv", ld.r_valid, 0);
    chk("err_st_rv", st.r_valid, 0);
    chk("err_lrdy", o.lrdy, 1);
    chk("err_pre", err, 0);
    tick;
    o.r_valid = 0;
    mid;
    chk("err_set", err, 1);
    tick;
    mid;
    chk("err_sticky", err, 1);
    tick;

    // clear with three outstanding; turn is STORE beforehand
    ld.req = 1;
    for (int k = 0; k < 3; k++) tick;
    ld.req = 0;
    mid;
    chk("clr_occ3", occ, 3);
    clear_i = 1;
    tick;
    clear_i = 0;
    mid;
    chk("clr_occ", occ, 0);
    chk("clr_err", err, 0);
    ld.req = 1; st.req = 1;
    #1;
    chk("clr_turn_ld", ld.gnt, 1);
    chk("clr_turn_st", st.gnt, 0);
    tick;
    ld.req = 0; st.req = 0; o.r_valid = 1;
    mid;
    chk("clr_rv", ld.r_valid, 1);
    tick;
    mid;
    chk("clr_stale_rv", ld.r_valid, 0);
    tick;
    o.r_valid = 0;
    mid;
    chk("clr_stale_err", err, 1);
    tick;

    // starvation guard on the LOAD_WEIGHT=16 instance
    o2.gnt = 1; ld2.req = 1; st2.req = 1;
    for (int k = 0; k < 10; k++) begin
      o2.r_valid = (k > 0);
      mid;
      exp_s = STV && (k == 8);
      chk("stv_ld_gnt", ld2.gnt, !exp_s);
      chk("stv_st_gnt", st2.gnt, exp_s);
      chk("stv_flag", starve2, exp_s);
      tick;
    end
    ld2.req = 0; st2.req = 0; o2.r_valid = 1;
    tick;
    o2.r_valid = 0;
    mid;
    chk("stv_occ", occ2, 0);
    chk("stv_err", err2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
